// File: rtl/pc_stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_stack_sequencer                                                   |
// | Stack engine for CALL/RET/RTI; optional flags save via               |
// | PC_STACK_FLAGS_EN.                                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_stack_sequencer #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SP_RESET = 20'hFFFFF,
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       MEM_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_call,
  input  logic [PC_W-1:0]   i_ret_pc,
  input  logic              i_ret,
  input  logic              i_rti,
  input  logic [2:0]        i_flags,
  output logic              o_push_pc,
  output logic              o_pop_pc,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [MEM_W-1:0]  o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [MEM_W-1:0]  i_mem_rdata,
  output logic              o_redirect,
  output logic [PC_W-1:0]   o_redirect_pc,
  output logic [2:0]        o_flags,
  output logic [ADDR_W-1:0] o_sp
);

  localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_two   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_three = ADDR_W'(3);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PUSH_LO  = 4'd1,
    S_PUSH_HI  = 4'd2,
    S_PUSH_FLG = 4'd3,
    S_POP_FLG  = 4'd4,
    S_POP_HI   = 4'd5,
    S_POP_LO   = 4'd6,
    S_POP_WAIT = 4'd7,
    S_REDIRECT = 4'd8
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_sp;
  logic [PC_W-1:0]     r_pc;
  logic                r_flg;
  logic [2:0]          r_flags_sv;
  logic [2:0]          r_flags_rd;
  logic [MEM_W-1:0]    r_hi;
  logic [1:0]          r_acc;
  logic [1:0]          r_rcnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [MEM_W-1:0]    r_mem_wdata;
  logic                r_push;
  logic                r_pop;
  logic                r_redirect;
  logic [PC_W-1:0]     r_redirect_pc;
  logic [2:0]          r_flags_out;

  logic                w_rti;
  logic [2:0]          w_flags_in;

`ifdef PC_STACK_FLAGS_EN
  assign w_rti      = i_rti;
  assign w_flags_in = i_flags;
`else
  assign w_rti      = 1'b0;
  assign w_flags_in = 3'b000;
  logic  w_unused_ok;
  assign w_unused_ok = &{1'b0, i_rti, i_flags};
`endif

  logic       w_accept;
  logic       w_pop_state;
  logic       w_rd_take;
  logic [1:0] w_hi_idx;
  logic [1:0] w_last_idx;

  assign w_accept    = r_mem_req & i_mem_ready;
  assign w_pop_state = (r_state == S_POP_FLG) || (r_state == S_POP_HI) ||
                       (r_state == S_POP_LO)  || (r_state == S_POP_WAIT);
  // Only count rvalids that answer a read issued by this sequence.
  assign w_rd_take   = w_pop_state & i_mem_rvalid & (r_rcnt != r_acc);
  assign w_hi_idx    = r_flg ? 2'd1 : 2'd0;
  assign w_last_idx  = r_flg ? 2'd2 : 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_sp          <= SP_RESET;
      r_pc          <= '0;
      r_flg         <= 1'b0;
      r_flags_sv    <= '0;
      r_flags_rd    <= '0;
      r_hi          <= '0;
      r_acc         <= '0;
      r_rcnt        <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_push        <= 1'b0;
      r_pop         <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_flags_out   <= '0;
    end else begin
      r_redirect <= 1'b0;
      if (w_rd_take) begin
        r_rcnt <= r_rcnt + 2'd1;
        if (r_flg && r_rcnt == 2'd0) r_flags_rd <= i_mem_rdata[2:0];
        if (r_rcnt == w_hi_idx)      r_hi       <= i_mem_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (i_call) begin
            r_state     <= S_PUSH_LO;
            r_pc        <= i_ret_pc;
            r_flg       <= w_rti;
            r_flags_sv  <= w_flags_in;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_sp;
            r_mem_wdata <= i_ret_pc[MEM_W-1:0];
            r_push      <= 1'b1;
          end else if (i_ret) begin
            r_state    <= w_rti ? S_POP_FLG : S_POP_HI;
            r_flg      <= w_rti;
            r_acc      <= 2'd0;
            r_rcnt     <= 2'd0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_sp + c_one;
            r_pop      <= 1'b1;
          end
        end
        S_PUSH_LO: if (w_accept) begin
          r_state     <= S_PUSH_HI;
          r_mem_addr  <= r_mem_addr - c_one;
          r_mem_wdata <= r_pc[PC_W-1:MEM_W];
        end
        S_PUSH_HI: if (w_accept) begin
          if (r_flg) begin
            r_state     <= S_PUSH_FLG;
            r_mem_addr  <= r_mem_addr - c_one;
            r_mem_wdata <= {{(MEM_W-3){1'b0}}, r_flags_sv};
          end else begin
            r_state   <= S_IDLE;
            r_sp      <= r_sp - c_two;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_push    <= 1'b0;
          end
        end
        S_PUSH_FLG: if (w_accept) begin
          r_state   <= S_IDLE;
          r_sp      <= r_sp - c_three;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_push    <= 1'b0;
        end
        S_POP_FLG, S_POP_HI: if (w_accept) begin
          r_state    <= (r_state == S_POP_FLG) ? S_POP_HI : S_POP_LO;
          r_mem_addr <= r_mem_addr + c_one;
          r_acc      <= r_acc + 2'd1;
        end
        S_POP_LO: if (w_accept) begin
          r_state   <= S_POP_WAIT;
          r_mem_req <= 1'b0;
          r_acc     <= r_acc + 2'd1;
        end
        S_POP_WAIT: if (w_rd_take && r_rcnt == w_last_idx) begin
          r_state       <= S_REDIRECT;
          r_pop         <= 1'b0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= {r_hi, i_mem_rdata};
          r_flags_out   <= r_flg ? r_flags_rd : 3'b000;
          r_sp          <= r_sp + (r_flg ? c_three : c_two);
        end
        S_REDIRECT: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign o_push_pc     = r_push;
  assign o_pop_pc      = r_pop;
  assign o_busy        = (r_state != S_IDLE);
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_flags       = r_flags_out;
  assign o_sp          = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_stack_sequencer                                                |
// | Directed scoreboard bench for pc_stack_sequencer (PC_STACK_FLAGS_EN  |
// | aware). Rev 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_pc_stack_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, call, ret, rti, mem_ready, mem_rvalid;
  logic [31:0] ret_pc;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        push_pc, pop_pc, busy, mem_req, mem_we, redirect;
  logic [19:0] mem_addr, sp;
  logic [15:0] mem_wdata;
  logic [31:0] redirect_pc;
  logic [2:0]  flags_out;

  logic        z_call;
  logic [31:0] z_pc;
  logic        z_push, z_pop, z_busy, z_req, z_we, z_redir;
  logic [19:0] z_addr, z_sp;
  logic [15:0] z_wdata;
  logic [31:0] z_rpc;
  logic [2:0]  z_flags;

  pc_stack_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_call(call), .i_ret_pc(ret_pc), .i_ret(ret),
    .i_rti(rti), .i_flags(flags_in), .o_push_pc(push_pc), .o_pop_pc(pop_pc),
    .o_busy(busy), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_flags(flags_out), .o_sp(sp)
  );

  pc_stack_sequencer #(.SP_RESET(20'h00000)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_call(z_call), .i_ret_pc(z_pc), .i_ret(1'b0),
    .i_rti(1'b0), .i_flags(3'b000), .o_push_pc(z_push), .o_pop_pc(z_pop),
    .o_busy(z_busy), .o_mem_req(z_req), .o_mem_we(z_we), .o_mem_addr(z_addr),
    .o_mem_wdata(z_wdata), .i_mem_ready(1'b1), .i_mem_rvalid(1'b0),
    .i_mem_rdata(16'h0000), .o_redirect(z_redir), .o_redirect_pc(z_rpc),
    .o_flags(z_flags), .o_sp(z_sp)
  );

  typedef struct { logic we; logic [19:0] addr; logic [15:0] data; } req_t;
  req_t        exp_req[$];
  logic [31:0] exp_redir[$];
  logic [2:0]  exp_flg[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem [logic [19:0]];
  logic        hold_rvalid;
  int n_tests = 0, n_fail = 0;
  int push_cnt = 0, pop_cnt = 0, redir_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [19:0] a, input logic [15:0] d);
    exp_req.push_back('{1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [19:0] a);
    exp_req.push_back('{1'b0, a, 16'h0000});
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) return;
      cycles++;
    end
    n_tests++;
    assert (!busy) else begin
      n_fail++;
      $error("FAIL idle_timeout: observed busy after %0d cycles, expected idle", budget);
    end
  endtask

  // Memory responder and scoreboard: requests are checked when accepted,
  // read data returns one cycle after accept.
  initial begin
    req_t e;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!hold_rvalid && rd_q.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_q.pop_front();
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
      end
      if (push_pc) push_cnt++;
      if (pop_pc)  pop_cnt++;
      if (rst_n && mem_req && mem_ready) begin
        n_tests++;
        assert (exp_req.size() != 0) else begin
          n_fail++;
          $error("FAIL req_unexpected: observed we=%0b addr=%0h, expected no request", mem_we, mem_addr);
        end
        if (exp_req.size() != 0) begin
          e = exp_req.pop_front();
          check("req_we", mem_we, e.we);
          check("req_addr", mem_addr, e.addr);
          if (e.we) begin
            check("req_wdata", mem_wdata, e.data);
            mem[mem_addr] = mem_wdata;
          end else begin
            rd_q.push_back(mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000);
          end
        end else if (!mem_we) begin
          rd_q.push_back(16'h0000);
        end
      end
      if (redirect) begin
        redir_cnt++;
        n_tests++;
        assert (exp_redir.size() != 0) else begin
          n_fail++;
          $error("FAIL redirect_unexpected: observed pc %0h, expected no redirect", redirect_pc);
        end
        if (exp_redir.size() != 0) begin
          check("redirect_pc", redirect_pc, exp_redir.pop_front());
          check("redirect_flags", flags_out, exp_flg.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, p0, q0, r0;
    logic [19:0] sp_after;
    rst_n = 1'b0; call = 1'b0; ret = 1'b0; rti = 1'b0; ret_pc = '0;
    flags_in = '0; mem_ready = 1'b1; hold_rvalid = 1'b0; z_call = 1'b0; z_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sp", sp, 20'hFFFFF);
    check("rst_outs", {mem_req, mem_we, push_pc, pop_pc, redirect, flags_out}, 0);
    check("rst_addr_data", {mem_addr, mem_wdata, redirect_pc}, 0);
    check("rst_z_sp", z_sp, 20'h00000);
    step(); rst_n = 1'b1;

    // Plain call
    exp_wr(20'hFFFFF, 16'h2345); exp_wr(20'hFFFFE, 16'h0001);
    p0 = push_cnt;
    call = 1'b1; ret_pc = 32'h0001_2345;
    step(); call = 1'b0;
    wait_idle(20, cyc);
    check("push_cycles", cyc, 2);
    check("push_sp", sp, 20'hFFFFD);
    check("push_pc_len", push_cnt - p0, 2);
    check("push_drained", exp_req.size(), 0);

    // Return
    exp_rd(20'hFFFFE); exp_rd(20'hFFFFF);
    exp_redir.push_back(32'h0001_2345); exp_flg.push_back(3'b000);
    r0 = redir_cnt; q0 = pop_cnt;
    ret = 1'b1;
    step(); ret = 1'b0;
    wait_idle(20, cyc);
    check("pop_cycles", cyc, 4);
    check("pop_redirects", redir_cnt - r0, 1);
    check("pop_pc_len", pop_cnt - q0, 3);
    check("pop_sp", sp, 20'hFFFFF);
    check("pop_redirect_pc_hold", redirect_pc, 32'h0001_2345);

    // Stall during PUSH_HI
    exp_wr(20'hFFFFF, 16'h1234); exp_wr(20'hFFFFE, 16'hABCD);
    call = 1'b1; ret_pc = 32'hABCD_1234;
    step(); call = 1'b0;
    step(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", {mem_req, mem_we, push_pc}, 3'b111);
      check("stall_addr", mem_addr, 20'hFFFFE);
      check("stall_wdata", mem_wdata, 16'hABCD);
      check("stall_sp", sp, 20'hFFFFF);
      step();
    end
    mem_ready = 1'b1;
    wait_idle(20, cyc);
    check("stall_sp_after", sp, 20'hFFFFD);

    // Simultaneous call/ret, then call while busy
    exp_wr(20'hFFFFD, 16'hAAAA); exp_wr(20'hFFFFC, 16'h5555);
    q0 = pop_cnt; r0 = redir_cnt;
    call = 1'b1; ret = 1'b1; ret_pc = 32'h5555_AAAA;
    step(); ret = 1'b0; ret_pc = 32'hDEAD_BEEF;
    step(); call = 1'b0;
    wait_idle(20, cyc);
    check("both_sp", sp, 20'hFFFFB);
    check("both_no_pop", pop_cnt - q0, 0);
    check("both_no_redirect", redir_cnt - r0, 0);
    check("both_drained", exp_req.size(), 0);
    exp_rd(20'hFFFFC); exp_rd(20'hFFFFD);
    exp_redir.push_back(32'h5555_AAAA); exp_flg.push_back(3'b000);
    ret = 1'b1;
    step(); ret = 1'b0;
    wait_idle(20, cyc);
    check("both_pop_sp", sp, 20'hFFFFD);
    check("both_pop_redirects", redir_cnt - r0, 1);

    // Reset while waiting for read data
    hold_rvalid = 1'b1;
    exp_rd(20'hFFFFE); exp_rd(20'hFFFFF);
    r0 = redir_cnt;
    ret = 1'b1;
    step(); ret = 1'b0;
    step(); step();
    @(negedge clk);
    check("wait_state", {busy, pop_pc, mem_req}, 3'b110);
    #1 rst_n = 1'b0;
    step(); rst_n = 1'b1; hold_rvalid = 1'b0;
    @(negedge clk);
    check("abort_busy", {busy, pop_pc, mem_req}, 3'b000);
    check("abort_sp", sp, 20'hFFFFF);
    check("abort_redirect_pc", redirect_pc, 32'h0);
    repeat (4) @(negedge clk);
    check("abort_no_redirect", redir_cnt - r0, 0);
    check("abort_rd_drained", rd_q.size(), 0);

    // Interrupt entry / RTI
`ifdef PC_STACK_FLAGS_EN
    exp_wr(20'hFFFFF, 16'h5678); exp_wr(20'hFFFFE, 16'h1234); exp_wr(20'hFFFFD, 16'h0005);
    sp_after = 20'hFFFFC;
`else
    exp_wr(20'hFFFFF, 16'h5678); exp_wr(20'hFFFFE, 16'h1234);
    sp_after = 20'hFFFFD;
`endif
    call = 1'b1; rti = 1'b1; flags_in = 3'b101; ret_pc = 32'h1234_5678;
    step(); call = 1'b0; rti = 1'b0; flags_in = 3'b000;
    wait_idle(20, cyc);
    check("irq_sp", sp, sp_after);
`ifdef PC_STACK_FLAGS_EN
    exp_rd(20'hFFFFD); exp_rd(20'hFFFFE); exp_rd(20'hFFFFF);
    exp_flg.push_back(3'b101);
`else
    exp_rd(20'hFFFFE); exp_rd(20'hFFFFF);
    exp_flg.push_back(3'b000);
`endif
    exp_redir.push_back(32'h1234_5678);
    r0 = redir_cnt;
    ret = 1'b1; rti = 1'b1;
    step(); ret = 1'b0; rti = 1'b0;
    wait_idle(20, cyc);
    check("rti_sp", sp, 20'hFFFFF);
    check("rti_redirects", redir_cnt - r0, 1);

    // Wraparound from SP = 0
    z_call = 1'b1; z_pc = 32'h0777_0888;
    step(); z_call = 1'b0;
    @(negedge clk);
    check("wrap_lo", {z_req, z_we, z_push, z_addr, z_wdata}, {3'b111, 20'h00000, 16'h0888});
    step();
    @(negedge clk);
    check("wrap_hi", {z_req, z_we, z_push, z_addr, z_wdata}, {3'b111, 20'hFFFFF, 16'h0777});
    step();
    @(negedge clk);
    check("wrap_sp", z_sp, 20'hFFFFE);
    check("wrap_idle", {z_busy, z_req, z_push, z_pop, z_redir, z_flags, z_rpc}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
